// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART controller: TX/RX state
//               encodings, parity mode decoding and parity calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE       = 3'd0,
        RX_START      = 3'd1,
        RX_DATA       = 3'd2,
        RX_PARITY     = 3'd3,
        RX_STOP       = 3'd4,
        RX_BREAK_WAIT = 3'd5
    } rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_e;

    // Elaboration-time decode of the PARITY string parameter.
    function automatic parity_mode_e parity_from_string(input string s);
        parity_mode_e m;
        m = PAR_NONE;
        if (s == "EVEN") m = PAR_EVEN;
        if (s == "ODD")  m = PAR_ODD;
        return m;
    endfunction

    // Parity over the low nbits of data; EVEN yields the XOR, ODD its inverse.
    function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                         input int nbits,
                                         input parity_mode_e mode);
        logic p;
        p = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Show-ahead synchronous FIFO. head_data presents the oldest
//               entry while empty is low. A push into a full FIFO is accepted
//               only when a pop happens in the same cycle.
// Ports       : clk, rst (async, active-high), push/push_data, pop,
//               head_data, empty, full, count (occupancy)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap on natural overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; nothing is visible while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl_fifo
// Description : Full-duplex UART with shared oversampling tick, configurable
//               frame format, majority-vote RX sampling, break/overrun
//               detection and a show-ahead receive FIFO.
// Ports       : clk, rst (async, active-high)
//               TX : tx_data, tx_valid, tx_ready, tx_busy, tx
//               RX : rx, rx_data, rx_parity_err, rx_frame_err, rx_valid,
//                    rx_ready, rx_break, rx_overrun, rx_fifo_count
// Revision    : 1.0 - initial release
// ============================================================================
module uart_ctrl_fifo
    import uart_pkg::*;
#(
    parameter int    CLK_FREQ      = 50_000_000,
    parameter int    BAUD_RATE     = 115_200,
    parameter int    OVERSAMPLE    = 16,
    parameter int    DATA_BITS     = 8,
    parameter string PARITY        = "NONE",
    parameter int    STOP_BITS     = 1,
    parameter int    RX_FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_BITS-1:0]               tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               tx_busy,
    output logic                               tx,
    input  logic                               rx,
    output logic [DATA_BITS-1:0]               rx_data,
    output logic                               rx_parity_err,
    output logic                               rx_frame_err,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic                               rx_break,
    output logic                               rx_overrun,
    output logic [$clog2(RX_FIFO_DEPTH+1)-1:0] rx_fifo_count
);
    localparam int           SAMPLE_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int           DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int           OS_W       = $clog2(OVERSAMPLE);
    localparam int           M          = OVERSAMPLE / 2;
    localparam parity_mode_e PMODE      = parity_from_string(PARITY);
    localparam bit           HAS_PAR    = (PMODE != PAR_NONE);
    localparam bit           PARITY_OK  = (PARITY == "NONE") || (PARITY == "EVEN") || (PARITY == "ODD");
    localparam int           FW         = DATA_BITS + 2;

    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_M_M1 = OS_W'(M - 1);
    localparam logic [OS_W-1:0] OS_M    = OS_W'(M);
    localparam logic [OS_W-1:0] OS_M_P1 = OS_W'(M + 1);
    localparam logic [3:0]      BIT_LAST = 4'(DATA_BITS - 1);

    // ---------------------------------------------------------------- checks
    if (SAMPLE_DIV < 1) begin : g_chk_div
        $error("uart_ctrl_fifo: SAMPLE_DIV < 1");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_chk_os
        $error("uart_ctrl_fifo: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
        $error("uart_ctrl_fifo: DATA_BITS out of range");
    end
    if (!PARITY_OK) begin : g_chk_par
        $error("uart_ctrl_fifo: PARITY must be NONE, EVEN or ODD");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_ctrl_fifo: STOP_BITS must be 1 or 2");
    end
    if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("uart_ctrl_fifo: RX_FIFO_DEPTH must be a power of 2 >= 2");
    end

    // ---------------------------------------------------------- tick generator
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    always_comb begin
        tick  = (div_q == DIV_W'(SAMPLE_DIV - 1));
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // ----------------------------------------------------------------- TX FSM
    tx_state_e            tx_state_q, tx_state_d;
    logic [OS_W-1:0]      tx_os_q, tx_os_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic                 tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_bit_end;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_bit_end = tick && (tx_os_q == OS_LAST);
        if (tick && tx_state_q != TX_IDLE) tx_os_d = tx_os_q + OS_W'(1);
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_state_d = TX_START;
                    tx_sh_d    = tx_data;
                    tx_par_d   = parity_calc(MAX_DATA_BITS'(tx_data), DATA_BITS, PMODE);
                    tx_os_d    = '0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == BIT_LAST) begin
                        tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
                        tx_stop_d  = 1'b0;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                        tx_sh_d  = tx_sh_q >> 1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_stop_d  = 1'b0;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_stop_q == 1'(STOP_BITS - 1)) tx_state_d = TX_IDLE;
                    else                                 tx_stop_d  = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (tx_bit_end) tx_os_d = '0;

        // Line level is registered from the next state so tx is glitch-free.
        case (tx_state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_sh_d[0];
            TX_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx_ready = (tx_state_q == TX_IDLE);
    assign tx_busy  = !tx_ready;
    assign tx       = tx_q;

    // ----------------------------------------------------------------- RX FSM
    rx_state_e            rx_state_q, rx_state_d;
    logic                 rx_meta_q, rx_sync_q;
    logic [OS_W-1:0]      rx_os_q, rx_os_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [1:0]           rx_smp_q, rx_smp_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_break_q, rx_break_d;
    logic                 rx_overrun_q, rx_overrun_d;
    logic                 rx_maj, rx_eval, rx_bit_end;
    logic                 rx_fe, rx_pe, rx_brk_frame;
    logic                 rx_push;
    logic                 fifo_pop, fifo_empty, fifo_full;
    logic [FW-1:0]        fifo_head;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_os_d    = rx_os_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_smp_d   = rx_smp_q;
        rx_par_d   = rx_par_q;
        rx_break_d = 1'b0;
        rx_push    = 1'b0;
        // Majority of the samples at M-1, M and the live sample at M+1.
        rx_maj     = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_sync_q) | (rx_smp_q[1] & rx_sync_q);
        rx_eval    = tick && (rx_os_q == OS_M_P1);
        rx_bit_end = tick && (rx_os_q == OS_LAST);
        rx_fe      = !rx_maj;
        rx_pe      = HAS_PAR && (rx_par_q != parity_calc(MAX_DATA_BITS'(rx_sh_q), DATA_BITS, PMODE));
        rx_brk_frame = (rx_sh_q == '0) && (!HAS_PAR || !rx_par_q) && !rx_maj;

        if (tick && rx_state_q != RX_IDLE && rx_state_q != RX_BREAK_WAIT) rx_os_d = rx_os_q + OS_W'(1);
        if (tick && rx_os_q == OS_M_M1) rx_smp_d[0] = rx_sync_q;
        if (tick && rx_os_q == OS_M)    rx_smp_d[1] = rx_sync_q;

        case (rx_state_q)
            RX_IDLE: begin
                if (tick && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_os_d    = '0;
                end
            end
            RX_START: begin
                if (rx_eval && rx_maj) begin
                    rx_state_d = RX_IDLE;
                end else if (rx_bit_end) begin
                    rx_state_d = RX_DATA;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (rx_eval) rx_sh_d = {rx_maj, rx_sh_q[DATA_BITS-1:1]};
                if (rx_bit_end) begin
                    if (rx_bit_q == BIT_LAST) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                    else                      rx_bit_d   = rx_bit_q + 4'd1;
                end
            end
            RX_PARITY: begin
                if (rx_eval)    rx_par_d   = rx_maj;
                if (rx_bit_end) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                // Leave at the stop midpoint so the next start edge is caught.
                if (rx_eval) begin
                    if (rx_brk_frame) begin
                        rx_break_d = 1'b1;
                        rx_state_d = RX_BREAK_WAIT;
                    end else begin
                        rx_push    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            RX_BREAK_WAIT: begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
        if (rx_bit_end) rx_os_d = '0;

        fifo_pop     = !fifo_empty && rx_ready;
        rx_overrun_d = rx_push && fifo_full && !fifo_pop;
    end

    uart_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data ({rx_fe, rx_pe, rx_sh_q}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (rx_fifo_count)
    );

    // Head fields are masked while empty so stale storage never leaks out.
    assign rx_valid      = !fifo_empty;
    assign rx_data       = fifo_empty ? '0   : fifo_head[DATA_BITS-1:0];
    assign rx_parity_err = fifo_empty ? 1'b0 : fifo_head[DATA_BITS];
    assign rx_frame_err  = fifo_empty ? 1'b0 : fifo_head[DATA_BITS+1];
    assign rx_break      = rx_break_q;
    assign rx_overrun    = rx_overrun_q;

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            tx_state_q   <= TX_IDLE;
            tx_os_q      <= '0;
            tx_bit_q     <= '0;
            tx_stop_q    <= 1'b0;
            tx_sh_q      <= '0;
            tx_par_q     <= 1'b0;
            tx_q         <= 1'b1;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_os_q      <= '0;
            rx_bit_q     <= '0;
            rx_sh_q      <= '0;
            rx_smp_q     <= 2'b11;
            rx_par_q     <= 1'b0;
            rx_break_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            tx_state_q   <= tx_state_d;
            tx_os_q      <= tx_os_d;
            tx_bit_q     <= tx_bit_d;
            tx_stop_q    <= tx_stop_d;
            tx_sh_q      <= tx_sh_d;
            tx_par_q     <= tx_par_d;
            tx_q         <= tx_d;
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            rx_os_q      <= rx_os_d;
            rx_bit_q     <= rx_bit_d;
            rx_sh_q      <= rx_sh_d;
            rx_smp_q     <= rx_smp_d;
            rx_par_q     <= rx_par_d;
            rx_break_q   <= rx_break_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_ctrl_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_ctrl_fifo
// Description : Directed self-checking bench for uart_ctrl_fifo. An 8N1
//               instance covers TX, framing, break, overrun, glitch and reset;
//               an 8E1 instance covers parity. Received entries are checked
//               against scoreboard queues filled when frames are driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ctrl_fifo;
    localparam int BIT_CLK = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_parity_err, rx_frame_err, rx_valid, rx_break, rx_overrun;
    logic       rx_ready = 1'b1;
    logic [4:0] rx_fifo_count;

    logic       rx_e = 1'b1;
    logic [7:0] rx_data_e;
    logic       tx_ready_e, tx_busy_e, tx_e;
    logic       rx_parity_err_e, rx_frame_err_e, rx_valid_e, rx_break_e, rx_overrun_e;
    logic [4:0] rx_fifo_count_e;

    int checks = 0;
    int failures = 0;
    int brk_cnt = 0;
    int ovr_cnt = 0;
    logic [9:0] sb [$];
    logic [9:0] sb_e [$];

    always #5 clk = ~clk;

    uart_ctrl_fifo #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY("NONE"), .STOP_BITS(1), .RX_FIFO_DEPTH(16)
    ) u_dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx(tx), .rx(rx_in),
        .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_break(rx_break),
        .rx_overrun(rx_overrun), .rx_fifo_count(rx_fifo_count)
    );

    uart_ctrl_fifo #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY("EVEN"), .STOP_BITS(1), .RX_FIFO_DEPTH(16)
    ) u_dut_e (
        .clk(clk), .rst(rst), .tx_data(8'h00), .tx_valid(1'b0),
        .tx_ready(tx_ready_e), .tx_busy(tx_busy_e), .tx(tx_e), .rx(rx_e),
        .rx_data(rx_data_e), .rx_parity_err(rx_parity_err_e), .rx_frame_err(rx_frame_err_e),
        .rx_valid(rx_valid_e), .rx_ready(1'b1), .rx_break(rx_break_e),
        .rx_overrun(rx_overrun_e), .rx_fifo_count(rx_fifo_count_e)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumers: compare every popped head against the queue.
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            check("rx_pop_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("rx_entry", {22'd0, rx_frame_err, rx_parity_err, rx_data}, {22'd0, sb.pop_front()});
        end
        if (!rst && rx_valid_e) begin
            check("rx_e_pop_expected", 32'(sb_e.size() != 0), 32'd1);
            if (sb_e.size() != 0) check("rx_e_entry", {22'd0, rx_frame_err_e, rx_parity_err_e, rx_data_e}, {22'd0, sb_e.pop_front()});
        end
        if (rx_break)   brk_cnt++;
        if (rx_overrun) ovr_cnt++;
    end

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_e = v; else rx_in = v;
        repeat (BIT_CLK) @(posedge clk);
    endtask

    // Start, 8 data bits LSB first, optional parity, one stop, one idle bit.
    task automatic send_rx(input bit sel, input logic [7:0] d, input bit has_par,
                           input logic par, input logic stop);
        @(posedge clk); #1;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, par);
        drive_bit(sel, stop);
        drive_bit(sel, 1'b1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] exp_bits;
        int n;
        int brk0;

        // ---------------- reset state
        repeat (4) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_count", 32'(rx_fifo_count), 32'd0);
        check("rst_flags", {29'd0, rx_break, rx_overrun, rx_frame_err | rx_parity_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- TX 8N1 0xA5
        repeat (3) @(posedge clk); #1;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check("tx_ready_fall", 32'(tx_ready), 32'd0);
        check("tx_busy_rise", 32'(tx_busy), 32'd1);
        exp_bits = {1'b1, 8'hA5, 1'b0};
        n = 1;
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? 79 : 160) @(posedge clk);
            #1;
            n += (i == 0) ? 79 : 160;
            check($sformatf("tx_bit%0d", i), 32'(tx), 32'(exp_bits[i]));
        end
        while (!tx_ready && n < 1700) begin
            @(posedge clk); #1;
            n++;
        end
        check("tx_frame_len_ok", 32'(n >= 1580 && n <= 1610), 32'd1);

        // ---------------- RX 8E1 parity good / bad
        sb_e.push_back({2'b00, 8'h3C});
        send_rx(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        sb_e.push_back({2'b01, 8'h3C});
        send_rx(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
        check("parity_sb_drained", 32'(sb_e.size()), 32'd0);

        // ---------------- frame error, not a break
        brk0 = brk_cnt;
        sb.push_back({2'b10, 8'h55});
        send_rx(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        check("ferr_sb_drained", 32'(sb.size()), 32'd0);
        check("ferr_no_break", 32'(brk_cnt - brk0), 32'd0);

        // ---------------- break then a good frame
        brk0 = brk_cnt;
        @(posedge clk); #1;
        rx_in = 1'b0;
        repeat (15 * BIT_CLK) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (2 * BIT_CLK) @(posedge clk);
        check("break_pulses", 32'(brk_cnt - brk0), 32'd1);
        check("break_no_push", 32'(rx_fifo_count), 32'd0);
        sb.push_back({2'b00, 8'h12});
        send_rx(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        check("after_break_sb_drained", 32'(sb.size()), 32'd0);

        // ---------------- glitch: false start
        rx_ready = 1'b0;
        @(posedge clk); #1;
        rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (12 * BIT_CLK) @(posedge clk);
        check("glitch_no_frame", 32'(rx_fifo_count), 32'd0);

        // ---------------- overrun: 17 frames into a 16-deep FIFO
        ovr_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back({2'b00, 8'(8'h40 + i)});
            send_rx(1'b0, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
        end
        check("ovr_count_full", 32'(rx_fifo_count), 32'd16);
        check("ovr_pulses", 32'(ovr_cnt), 32'd1);
        @(posedge clk); #1;
        rx_ready = 1'b1;
        n = 0;
        while (rx_fifo_count != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ovr_drain_done", 32'(rx_fifo_count), 32'd0);
        check("ovr_sb_drained", 32'(sb.size()), 32'd0);

        // ---------------- reset mid-TX with a byte waiting in the FIFO
        rx_ready = 1'b0;
        sb.push_back({2'b00, 8'h77});
        send_rx(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
        check("pre_rst_count", 32'(rx_fifo_count), 32'd1);
        @(posedge clk); #1;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (500) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_tx_ready", 32'(tx_ready), 32'd1);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check("midrst_count", 32'(rx_fifo_count), 32'd0);
        check("midrst_rx_data", 32'(rx_data), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        rx_ready = 1'b1;
        repeat (20) @(posedge clk); #1;
        check("post_rst_idle", {30'd0, tx, tx_ready}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
